apb2axi: RTL and testbench

//  APB slave to AXI4 master bridge; the inverse direction of the AXI-to-APB bridge.

---
 rtl/apb2axi_pkg.sv | 27 ++
 rtl/apb2axi_lane.sv | 42 ++++
 rtl/apb2axi.sv | 260 ++++++++++++++++++++++++++
 tb/tb_apb2axi.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb2axi_pkg.sv
// apb2axi_pkg: shared constants for the APB-to-AXI4 bridge.
//   - FSM state encodings (legacy-compatible localparam constants)
//   - AXI response, burst and size encodings
//   - resp_is_err(): maps an AXI response onto the APB error flag
package apb2axi_pkg;

   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StWrReq  = 3'd1;
   localparam logic [2:0] StRdReq  = 3'd2;
   localparam logic [2:0] StWrResp = 3'd3;
   localparam logic [2:0] StRdResp = 3'd4;
   localparam logic [2:0] StDone   = 3'd5;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [2:0] SIZE_4B        = 3'b010;

   // SLVERR and DECERR are errors; OKAY and EXOKAY are not.
   function automatic logic resp_is_err(input logic [1:0] resp);
      return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
   endfunction

endpackage

// File: rtl/apb2axi_lane.sv
// apb2axi_lane: combinational lane steering between the 32-bit APB side and the
// wide AXI data bus.
// Ports:
//   addr_i   AXI request address (lane taken from bits [log2(DW/8)-1:2])
//   wdata_i  32-bit write data, replicated on every lane of wdata_o
//   strb_i   4-bit byte strobe, placed on the addressed lane of wstrb_o
//   rdata_i  AXI read data; rdata_o is the addressed 32-bit lane
module apb2axi_lane #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 64
) (
   input  logic [ADDR_WIDTH-1:0]   addr_i,
   input  logic [31:0]             wdata_i,
   input  logic [3:0]              strb_i,
   input  logic [DATA_WIDTH-1:0]   rdata_i,
   output logic [DATA_WIDTH-1:0]   wdata_o,
   output logic [DATA_WIDTH/8-1:0] wstrb_o,
   output logic [31:0]             rdata_o
);

   localparam int unsigned NumLanes = DATA_WIDTH / 32;
   // Keep the lane index at least one bit wide so a 32-bit bus still elaborates.
   localparam int unsigned LaneBits = (NumLanes > 1) ? $clog2(NumLanes) : 1;

   logic [LaneBits-1:0] lane;

   // Only the lane-select bits of the address matter here.
   logic unused_addr;
   assign unused_addr = ^addr_i;

   always_comb begin
      lane = '0;
      if (NumLanes > 1) begin
         lane = addr_i[LaneBits+1:2];
      end
      wdata_o = {NumLanes{wdata_i}};
      wstrb_o = '0;
      wstrb_o[4*lane +: 4] = strb_i;
      rdata_o = rdata_i[32*lane +: 32];
   end

endmodule

// File: rtl/apb2axi.sv
// apb2axi: APB slave to AXI4 master bridge. Each APB transfer becomes one
// single-beat 32-bit AXI read or write; pready is held low until the AXI
// response returns, and SLVERR/DECERR map onto pslverr.
// Configuration macro: APB2AXI_PSTRB_EN adds the APB4 pstrb_i port; without it
// every write uses byte strobe 4'hF (APB3).
// Ports:
//   clk_i, rstn_i              clock, synchronous active-low reset
//   psel_i .. pwdata_i         APB request, pstrb_i only with APB2AXI_PSTRB_EN
//   pready_o/pslverr_o/prdata_o APB completion
//   aw*/w*/b*                  AXI write address / data / response channels
//   ar*/r*                     AXI read address / data channels
module apb2axi
   import apb2axi_pkg::*;
#(
   parameter int unsigned AXI_ID_WIDTH   = 6,
   parameter int unsigned AXI_ADDR_WIDTH = 32,
   parameter int unsigned AXI_DATA_WIDTH = 64,
   parameter int unsigned APB_ADDR_WIDTH = 12,
   parameter logic [AXI_ID_WIDTH-1:0]   AXI_ID        = '0,
   parameter logic [AXI_ADDR_WIDTH-1:0] AXI_BASE_ADDR = '0
) (
   input  logic                        clk_i,
   input  logic                        rstn_i,
   // APB slave
   input  logic                        psel_i,
   input  logic                        penable_i,
   input  logic                        pwrite_i,
   input  logic [APB_ADDR_WIDTH-1:0]   paddr_i,
   input  logic [31:0]                 pwdata_i,
`ifdef APB2AXI_PSTRB_EN
   input  logic [3:0]                  pstrb_i,
`endif
   output logic                        pready_o,
   output logic                        pslverr_o,
   output logic [31:0]                 prdata_o,
   // AXI write address
   output logic [AXI_ID_WIDTH-1:0]     awid_o,
   output logic [AXI_ADDR_WIDTH-1:0]   awaddr_o,
   output logic [7:0]                  awlen_o,
   output logic [2:0]                  awsize_o,
   output logic [1:0]                  awburst_o,
   output logic                        awvalid_o,
   input  logic                        awready_i,
   // AXI write data
   output logic [AXI_DATA_WIDTH-1:0]   wdata_o,
   output logic [AXI_DATA_WIDTH/8-1:0] wstrb_o,
   output logic                        wlast_o,
   output logic                        wvalid_o,
   input  logic                        wready_i,
   // AXI write response
   input  logic [AXI_ID_WIDTH-1:0]     bid_i,
   input  logic [1:0]                  bresp_i,
   input  logic                        bvalid_i,
   output logic                        bready_o,
   // AXI read address
   output logic [AXI_ID_WIDTH-1:0]     arid_o,
   output logic [AXI_ADDR_WIDTH-1:0]   araddr_o,
   output logic [7:0]                  arlen_o,
   output logic [2:0]                  arsize_o,
   output logic [1:0]                  arburst_o,
   output logic                        arvalid_o,
   input  logic                        arready_i,
   // AXI read data
   input  logic [AXI_ID_WIDTH-1:0]     rid_i,
   input  logic [AXI_DATA_WIDTH-1:0]   rdata_i,
   input  logic [1:0]                  rresp_i,
   input  logic                        rlast_i,
   input  logic                        rvalid_i,
   output logic                        rready_o
);

   logic [2:0]                state_q, state_d;
   logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]               pwdata_q, pwdata_d;
   logic [3:0]                strb_q, strb_d;
   logic                      awvalid_q, awvalid_d;
   logic                      wvalid_q, wvalid_d;
   logic                      aw_done_q, aw_done_d;
   logic                      w_done_q, w_done_d;
   logic                      arvalid_q, arvalid_d;
   logic                      bready_q, bready_d;
   logic                      rready_q, rready_d;
   logic                      pready_q, pready_d;
   logic                      pslverr_q, pslverr_d;
   logic [31:0]               prdata_q, prdata_d;

   logic        aw_hs, w_hs;
   logic [3:0]  strb_in;
   logic [31:0] rdata_lane;

   // Single beat only: IDs and RLAST carry no information, low address bits are dropped.
   logic unused_in;
   assign unused_in = ^{bid_i, rid_i, rlast_i, paddr_i[1:0]};

`ifdef APB2AXI_PSTRB_EN
   assign strb_in = pstrb_i;
`else
   assign strb_in = 4'hF;
`endif

   assign aw_hs = awvalid_q & awready_i;
   assign w_hs  = wvalid_q & wready_i;

   apb2axi_lane #(
      .ADDR_WIDTH (AXI_ADDR_WIDTH),
      .DATA_WIDTH (AXI_DATA_WIDTH)
   ) u_lane (
      .addr_i  (addr_q),
      .wdata_i (pwdata_q),
      .strb_i  (strb_q),
      .rdata_i (rdata_i),
      .wdata_o (wdata_o),
      .wstrb_o (wstrb_o),
      .rdata_o (rdata_lane)
   );

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      pwdata_d  = pwdata_q;
      strb_d    = strb_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      arvalid_d = arvalid_q;
      bready_d  = bready_q;
      rready_d  = rready_q;
      pready_d  = pready_q;
      pslverr_d = pslverr_q;
      prdata_d  = prdata_q;

      case (state_q)
         StIdle: begin
            // Setup phase; the APB access phase is covered by the wait states below.
            if (psel_i && !penable_i) begin
               addr_d   = AXI_BASE_ADDR |
                          AXI_ADDR_WIDTH'({paddr_i[APB_ADDR_WIDTH-1:2], 2'b00});
               pwdata_d = pwdata_i;
               strb_d   = strb_in;
               if (pwrite_i) begin
                  state_d   = StWrReq;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  aw_done_d = 1'b0;
                  w_done_d  = 1'b0;
               end else begin
                  state_d   = StRdReq;
                  arvalid_d = 1'b1;
               end
            end
         end
         StWrReq: begin
            if (aw_hs) begin
               awvalid_d = 1'b0;
               aw_done_d = 1'b1;
            end
            if (w_hs) begin
               wvalid_d = 1'b0;
               w_done_d = 1'b1;
            end
            // Covers both handshakes landing in the same cycle.
            if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
               state_d  = StWrResp;
               bready_d = 1'b1;
            end
         end
         StWrResp: begin
            if (bvalid_i) begin
               bready_d  = 1'b0;
               pslverr_d = resp_is_err(bresp_i);
               pready_d  = 1'b1;
               state_d   = StDone;
            end
         end
         StRdReq: begin
            if (arready_i) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = StRdResp;
            end
         end
         StRdResp: begin
            if (rvalid_i) begin
               rready_d  = 1'b0;
               prdata_d  = rdata_lane;
               pslverr_d = resp_is_err(rresp_i);
               pready_d  = 1'b1;
               state_d   = StDone;
            end
         end
         StDone: begin
            // pready/pslverr live for exactly this cycle; prdata stays until the next read.
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
            state_d   = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q   <= StIdle;
         addr_q    <= '0;
         pwdata_q  <= '0;
         strb_q    <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         arvalid_q <= 1'b0;
         bready_q  <= 1'b0;
         rready_q  <= 1'b0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         pwdata_q  <= pwdata_d;
         strb_q    <= strb_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         arvalid_q <= arvalid_d;
         bready_q  <= bready_d;
         rready_q  <= rready_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         prdata_q  <= prdata_d;
      end
   end

   assign pready_o  = pready_q;
   assign pslverr_o = pslverr_q;
   assign prdata_o  = prdata_q;

   assign awid_o    = AXI_ID;
   assign awaddr_o  = addr_q;
   assign awlen_o   = 8'd0;
   assign awsize_o  = SIZE_4B;
   assign awburst_o = AXI_BURST_INCR;
   assign awvalid_o = awvalid_q;
   assign wlast_o   = 1'b1;
   assign wvalid_o  = wvalid_q;
   assign bready_o  = bready_q;

   assign arid_o    = AXI_ID;
   assign araddr_o  = addr_q;
   assign arlen_o   = 8'd0;
   assign arsize_o  = SIZE_4B;
   assign arburst_o = AXI_BURST_INCR;
   assign arvalid_o = arvalid_q;
   assign rready_o  = rready_q;

endmodule

// File: tb/tb_apb2axi.sv
// tb_apb2axi: self-checking bench for apb2axi (AXI_DATA_WIDTH = 64, base 0).
// An APB master and a delay-programmable AXI slave run cycle by cycle; the
// expected address, lane strobes, data, error flag and APB latency come from a
// transaction-level model.
module tb_apb2axi;

   logic        clk = 1'b0;
   logic        rstn;
   logic        psel, penable, pwrite;
   logic [11:0] paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic        pready, pslverr;
   logic [31:0] prdata;
   logic [5:0]  awid, arid, bid, rid;
   logic [31:0] awaddr, araddr;
   logic [7:0]  awlen, arlen;
   logic [2:0]  awsize, arsize;
   logic [1:0]  awburst, arburst, bresp, rresp;
   logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
   logic        arvalid, arready, rvalid, rready, rlast;
   logic [63:0] wdata, rdata;
   logic [7:0]  wstrb;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] model_prdata = '0;

   always #5 clk = ~clk;

   apb2axi #(
      .AXI_DATA_WIDTH (64)
   ) dut (
      .clk_i      (clk),
      .rstn_i     (rstn),
      .psel_i     (psel),
      .penable_i  (penable),
      .pwrite_i   (pwrite),
      .paddr_i    (paddr),
      .pwdata_i   (pwdata),
`ifdef APB2AXI_PSTRB_EN
      .pstrb_i    (pstrb),
`endif
      .pready_o   (pready),
      .pslverr_o  (pslverr),
      .prdata_o   (prdata),
      .awid_o     (awid),
      .awaddr_o   (awaddr),
      .awlen_o    (awlen),
      .awsize_o   (awsize),
      .awburst_o  (awburst),
      .awvalid_o  (awvalid),
      .awready_i  (awready),
      .wdata_o    (wdata),
      .wstrb_o    (wstrb),
      .wlast_o    (wlast),
      .wvalid_o   (wvalid),
      .wready_i   (wready),
      .bid_i      (bid),
      .bresp_i    (bresp),
      .bvalid_i   (bvalid),
      .bready_o   (bready),
      .arid_o     (arid),
      .araddr_o   (araddr),
      .arlen_o    (arlen),
      .arsize_o   (arsize),
      .arburst_o  (arburst),
      .arvalid_o  (arvalid),
      .arready_i  (arready),
      .rid_i      (rid),
      .rdata_i    (rdata),
      .rresp_i    (rresp),
      .rlast_i    (rlast),
      .rvalid_i   (rvalid),
      .rready_o   (rready)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0; bid = '0;
      arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rid = '0; rlast = 1'b1;
   endtask

   // One APB transfer. For reads, aw_d/b_d serve as AR/R delays.
   // abort_k != 0: pulse reset at that cycle (expects the write to be in its B phase).
   task automatic xfer(input bit wr, input logic [11:0] pa, input logic [31:0] pd,
                       input logic [3:0] ps, input int aw_d, input int w_d, input int b_d,
                       input logic [1:0] resp, input logic [63:0] rd, input int abort_k);
      logic [31:0] exp_addr;
      logic [7:0]  exp_strb;
      logic [3:0]  byte_strb;
      logic [31:0] exp_prdata;
      int lane, exp_lat, aw_n, w_n, ar_n, b_n, r_n, aw_k, w_k, ar_k;
      int aw_seen, w_seen, ar_seen, prot;
      bit done, both;
      exp_addr = {20'b0, pa[11:2], 2'b00};
      lane     = int'(exp_addr[2]);
`ifdef APB2AXI_PSTRB_EN
      byte_strb = ps;
`else
      byte_strb = 4'hF;
`endif
      exp_strb   = 8'(byte_strb) << (4 * lane);
      exp_prdata = wr ? model_prdata : rd[32*lane +: 32];
      exp_lat    = wr ? 3 + ((aw_d > w_d) ? aw_d : w_d) + b_d : 3 + aw_d + b_d;
      aw_n = 0; w_n = 0; ar_n = 0; b_n = 0; r_n = 0; aw_k = 0; w_k = 0; ar_k = 0;
      aw_seen = 0; w_seen = 0; ar_seen = 0; prot = 0; done = 0;

      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = pa; pwdata = pd; pstrb = ps;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (k == 1) penable = 1'b1;
         if (abort_k != 0 && k == abort_k) begin
            check_eq("abort_in_b_phase", {63'b0, bready}, 64'd1);
            rstn = 1'b0;
            clear_inputs();
            @(negedge clk);
            check_eq("abort_valids", {59'b0, awvalid, wvalid, arvalid, bready, rready}, 64'd0);
            check_eq("abort_pready", {63'b0, pready}, 64'd0);
            rstn = 1'b1;
            model_prdata = '0;
            return;
         end
         // Write address / data: VALID held until its own handshake, then dropped.
         if (wr && aw_n == 0 && !awvalid) prot++;
         if (awvalid && (aw_n != 0 || !wr)) prot++;
         awready = awvalid && (aw_seen >= aw_d);
         if (awvalid) aw_seen++;
         if (awvalid && awready) begin
            aw_n++; aw_k = k;
            check_eq("awaddr", {32'b0, awaddr}, {32'b0, exp_addr});
         end
         if (wr && w_n == 0 && !wvalid) prot++;
         if (wvalid && (w_n != 0 || !wr)) prot++;
         wready = wvalid && (w_seen >= w_d);
         if (wvalid) w_seen++;
         if (wvalid && wready) begin
            w_n++; w_k = k;
            check_eq("wdata", wdata, {pd, pd});
            check_eq("wstrb", {56'b0, wstrb}, {56'b0, exp_strb});
         end
         // Read address
         if (!wr && ar_n == 0 && !arvalid) prot++;
         if (arvalid && (ar_n != 0 || wr)) prot++;
         arready = arvalid && (ar_seen >= aw_d);
         if (arvalid) ar_seen++;
         if (arvalid && arready) begin
            ar_n++; ar_k = k;
            check_eq("araddr", {32'b0, araddr}, {32'b0, exp_addr});
         end
         // Write response: BREADY only after both handshakes have completed.
         both = (aw_n == 1) && (w_n == 1) && (aw_k < k) && (w_k < k);
         if (bready && (!both || b_n != 0)) prot++;
         bvalid = both && (b_n == 0) && (k >= ((aw_k > w_k) ? aw_k : w_k) + 1 + b_d);
         bresp  = resp;
         if (bvalid && bready) b_n++;
         // Read data
         if (rready && (ar_n == 0 || ar_k >= k || r_n != 0)) prot++;
         rvalid = (ar_n == 1) && (ar_k < k) && (r_n == 0) && (k >= ar_k + 1 + b_d);
         rdata  = rd;
         rresp  = resp;
         if (rvalid && rready) r_n++;
         if (pready) begin
            check_eq("latency", 64'(k), 64'(exp_lat));
            check_eq("pslverr", {63'b0, pslverr}, {63'b0, resp[1]});
            check_eq("prdata", {32'b0, prdata}, {32'b0, exp_prdata});
            done = 1;
            break;
         end
      end
      if (!done) check_eq("timeout", 64'd0, 64'd1);
      check_eq("handshake_counts", {32'b0, 8'(aw_n), 8'(w_n), 8'(ar_n), 8'(b_n + r_n)},
               wr ? 64'h0101_0001 : 64'h0000_0101);
      check_eq("protocol", 64'(prot), 64'd0);
      if (!wr) model_prdata = exp_prdata;
      @(posedge clk);
      #1;
      clear_inputs();
      @(negedge clk);
      check_eq("pready_pulse", {63'b0, pready}, 64'd0);
   endtask

   initial begin
      rstn = 1'b0;
      clear_inputs();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_valids", {59'b0, awvalid, wvalid, arvalid, bready, rready}, 64'd0);
      check_eq("rst_apb", {30'b0, pready, pslverr, prdata}, 64'd0);
      check_eq("tied_aw", {40'b0, awid, awlen, awsize, awburst, wlast},
               {40'b0, 6'd0, 8'd0, 3'b010, 2'b01, 1'b1});
      check_eq("tied_ar", {42'b0, arid, arlen, arsize, arburst}, {42'b0, 6'd0, 8'd0, 3'b010, 2'b01});
      rstn = 1'b1;

      // Ready-slave write to the upper lane.
      xfer(1'b1, 12'h014, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, 64'd0, 0);
      // Reads from both lanes.
      xfer(1'b0, 12'h010, 32'd0, 4'h0, 0, 0, 0, 2'b00, 64'h11112222_33334444, 0);
      xfer(1'b0, 12'h014, 32'd0, 4'h0, 0, 0, 0, 2'b00, 64'h11112222_33334444, 0);
      // AWREADY late by 3, WREADY late by 1.
      xfer(1'b1, 12'h020, 32'h0BADF00D, 4'hF, 3, 1, 0, 2'b00, 64'd0, 0);
      // Error responses.
      xfer(1'b1, 12'h030, 32'h12345678, 4'hF, 0, 0, 1, 2'b10, 64'd0, 0);
      xfer(1'b0, 12'h034, 32'd0, 4'h0, 1, 0, 0, 2'b11, 64'hCAFE0001_CAFE0002, 0);
      xfer(1'b0, 12'h038, 32'd0, 4'h0, 0, 0, 2, 2'b01, 64'hA5A5A5A5_5A5A5A5A, 0);
      // Reset while waiting for B, then a normal read.
      xfer(1'b1, 12'h040, 32'h55AA55AA, 4'hF, 0, 0, 6, 2'b00, 64'd0, 3);
      check_eq("post_abort_prdata", {32'b0, prdata}, 64'd0);
      xfer(1'b0, 12'h044, 32'd0, 4'h0, 0, 0, 0, 2'b00, 64'h87654321_0FEDCBA9, 0);
      // Partial byte strobe on the lower lane.
      xfer(1'b1, 12'h010, 32'hFEEDFACE, 4'b0011, 0, 0, 0, 2'b00, 64'd0, 0);

      for (int i = 0; i < 40; i++) begin
         xfer(1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)), $urandom,
              4'($urandom_range(0, 15)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), {$urandom, $urandom}, 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
